// File: rtl/cbus_write_controller_pkg.sv
// Shared types and opcode field layout for the C-bus write controller.
// Opcode byte: [7:6] op, [5:4] dst, [3:2] unused, [1:0] MOV source.
package cbus_pkg;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_MOV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        DST_A    = 2'b00,
        DST_B    = 2'b01,
        DST_O    = 2'b10,
        DST_NONE = 2'b11
    } dst_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_IMM   = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int DST_HI = 5;
    localparam int DST_LO = 4;
    localparam int IGN_HI = 3;
    localparam int IGN_LO = 2;
    localparam int SRC_HI = 1;
    localparam int SRC_LO = 0;

    // Strobe vector ordered {A, B, O}; at most one bit set.
    function automatic logic [2:0] strobe_of(input dst_t d);
        logic [2:0] s;
        s = 3'b000;
        unique case (d)
            DST_A:    s = 3'b100;
            DST_B:    s = 3'b010;
            DST_O:    s = 3'b001;
            DST_NONE: s = 3'b000;
            default:  s = 3'b000;
        endcase
        return s;
    endfunction

    function automatic logic uses_carry(input op_t o);
        return (o == OP_ADD) || (o == OP_SUB);
    endfunction

endpackage

// File: rtl/cbus_write_controller_alu.sv
// Combinational result path for the C-bus controller.
// SUB reports borrow in carry_out; LDI/MOV carry_out is don't-care.
module cbus_alu
    import cbus_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    input  logic [1:0]       src,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH-1:0] mov_val;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        mov_val = '0;
        unique case (src)
            2'b00:   mov_val = a;
            2'b01:   mov_val = b;
            default: mov_val = '0;
        endcase
    end

    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        unique case (op)
            OP_LDI: result = imm;
            OP_ADD: begin
                result    = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
            end
            OP_SUB: begin
                result    = diff[WIDTH-1:0];
                carry_out = diff[WIDTH];
            end
            OP_MOV: result = mov_val;
            default: begin
                result    = '0;
                carry_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cbus_write_controller.sv
// C-bus write initiator: fetch/decode byte stream, drive CBus and one
// write strobe during EXEC, and keep carry/zero flags.
module cbus_write_controller
    import cbus_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InstrData,
    input  logic             InstrValid,
    output logic             InstrReady,
    input  logic [WIDTH-1:0] ABus,
    input  logic [WIDTH-1:0] BBus,
    output logic [WIDTH-1:0] CBus,
    output logic             WriteA,
    output logic             WriteB,
    output logic             WriteO,
    output logic             Carry,
    output logic             Zero,
    output logic             Busy
);

    state_t           state;
    op_t              op_q;
    dst_t             dst_q;
    logic [1:0]       src_q;
    logic [WIDTH-1:0] imm_q;
    logic             ready_q;
    logic             busy_q;
    logic             carry_q;
    logic             zero_q;
    logic [2:0]       stb_q;

    logic             xfer;
    op_t              in_op;
    dst_t             in_dst;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;
    logic             unused_ign;

    assign xfer       = InstrValid && ready_q;
    assign in_op      = op_t'(InstrData[OP_HI:OP_LO]);
    assign in_dst     = dst_t'(InstrData[DST_HI:DST_LO]);
    assign unused_ign = ^InstrData[IGN_HI:IGN_LO];

    cbus_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a         (ABus),
        .b         (BBus),
        .op        (op_q),
        .src       (src_q),
        .imm       (imm_q),
        .result    (alu_res),
        .carry_out (alu_cy)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_FETCH;
            op_q    <= OP_LDI;
            dst_q   <= DST_NONE;
            src_q   <= 2'b00;
            imm_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            stb_q   <= 3'b000;
        end else begin
            stb_q <= 3'b000;
            unique case (state)
                S_FETCH: begin
                    if (xfer) begin
                        op_q   <= in_op;
                        dst_q  <= in_dst;
                        src_q  <= InstrData[SRC_HI:SRC_LO];
                        busy_q <= 1'b1;
                        if (in_op == OP_LDI) begin
                            state <= S_IMM;
                        end else begin
                            state   <= S_EXEC;
                            ready_q <= 1'b0;
                            stb_q   <= strobe_of(in_dst);
                        end
                    end
                end
                S_IMM: begin
                    if (xfer) begin
                        imm_q   <= InstrData;
                        state   <= S_EXEC;
                        ready_q <= 1'b0;
                        stb_q   <= strobe_of(dst_q);
                    end
                end
                S_EXEC: begin
                    // Flags track the result even when nothing is written.
                    state   <= S_FETCH;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    zero_q  <= (alu_res == '0);
                    if (uses_carry(op_q)) begin
                        carry_q <= alu_cy;
                    end
                end
                default: begin
                    state   <= S_FETCH;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign CBus       = (state == S_EXEC) ? alu_res : '0;
    assign WriteA     = stb_q[2];
    assign WriteB     = stb_q[1];
    assign WriteO     = stb_q[0];
    assign Carry      = carry_q;
    assign Zero       = zero_q;
    assign InstrReady = ready_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_cbus_write_controller.sv
// Directed bench for cbus_write_controller with A/B/O register models
// that capture CBus on the strobes and feed ABus/BBus back.
module tb_cbus_write_controller;

    logic       Clock;
    logic       Reset;
    logic [7:0] InstrData;
    logic       InstrValid;
    logic       InstrReady;
    logic [7:0] ABus;
    logic [7:0] BBus;
    logic [7:0] CBus;
    logic       WriteA;
    logic       WriteB;
    logic       WriteO;
    logic       Carry;
    logic       Zero;
    logic       Busy;

    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] ro;
    int         nstb;
    int         checks;
    int         errors;
    int         saved;

    cbus_write_controller #(
        .WIDTH (8)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .InstrData  (InstrData),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .ABus       (ABus),
        .BBus       (BBus),
        .CBus       (CBus),
        .WriteA     (WriteA),
        .WriteB     (WriteB),
        .WriteO     (WriteO),
        .Carry      (Carry),
        .Zero       (Zero),
        .Busy       (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign ABus = ra;
    assign BBus = rb;

    initial begin
        ra   = 8'h00;
        rb   = 8'h00;
        ro   = 8'h00;
        nstb = 0;
    end

    always @(posedge Clock) begin
        if (WriteA) ra <= CBus;
        if (WriteB) rb <= CBus;
        if (WriteO) ro <= CBus;
        if (WriteA || WriteB || WriteO) nstb <= nstb + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (!Reset && checks > 0)
            check("onehot", 16'($countones({WriteA, WriteB, WriteO})), 16'd1 - 16'(!(WriteA || WriteB || WriteO)));
    end

    // Present a byte at a negedge; returns at the negedge after transfer.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        InstrData  = b;
        InstrValid = 1'b1;
        while (!InstrReady && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("send_ready", 16'(InstrReady), 16'd1);
        @(negedge Clock);
        InstrValid = 1'b0;
    endtask

    task automatic exec_chk(input string tag, input logic [2:0] stb,
                            input logic [7:0] cb);
        check({tag, "_stb"}, 16'({WriteA, WriteB, WriteO}), 16'(stb));
        check({tag, "_cbus"}, 16'(CBus), 16'(cb));
        check({tag, "_rdy"}, 16'(InstrReady), 16'd0);
    endtask

    task automatic flag_chk(input string tag, input logic c, input logic z);
        @(negedge Clock);
        check({tag, "_carry"}, 16'(Carry), 16'(c));
        check({tag, "_zero"}, 16'(Zero), 16'(z));
        check({tag, "_idle"}, 16'({WriteA, WriteB, WriteO, Busy}), 16'd0);
    endtask

    task automatic ldi(input logic [7:0] op, input logic [7:0] imm);
        send(op);
        send(imm);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        Reset      = 1'b1;
        InstrValid = 1'b0;
        InstrData  = 8'h00;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        check("rst_cbus", 16'(CBus), 16'h00);
        check("rst_stb", 16'({WriteA, WriteB, WriteO}), 16'd0);
        check("rst_flags", 16'({Carry, Zero}), 16'd0);
        check("rst_rdy", 16'(InstrReady), 16'd1);
        check("rst_busy", 16'(Busy), 16'd0);

        send(8'h00);
        check("ldi_imm_busy", 16'(Busy), 16'd1);
        check("ldi_imm_rdy", 16'(InstrReady), 16'd1);
        send(8'h0F);
        exec_chk("ldiA", 3'b100, 8'h0F);
        flag_chk("ldiA", 1'b0, 1'b0);
        check("ldiA_reg", 16'(ra), 16'h0F);

        ldi(8'h00, 8'hFF);
        flag_chk("ldiA2", 1'b0, 1'b0);
        ldi(8'h10, 8'h01);
        flag_chk("ldiB", 1'b0, 1'b0);
        send(8'h60);
        exec_chk("addO", 3'b001, 8'h00);
        flag_chk("addO", 1'b1, 1'b1);
        check("addO_reg", 16'(ro), 16'h00);
        ldi(8'h00, 8'h00);
        exec_chk("ldiA0", 3'b100, 8'h00);
        flag_chk("ldiA0", 1'b1, 1'b1);
        send(8'h80);
        exec_chk("subA", 3'b100, 8'hFF);
        flag_chk("subA", 1'b1, 1'b0);
        check("subA_reg", 16'(ra), 16'hFF);

        InstrValid = 1'b1;
        InstrData  = 8'h10;
        @(negedge Clock);
        check("b2b_imm", 16'({Busy, InstrReady}), 16'b11);
        InstrData = 8'h55;
        @(negedge Clock);
        exec_chk("b2b_ldiB", 3'b010, 8'h55);
        InstrData = 8'hC1;
        @(negedge Clock);
        check("b2b_fetch", 16'({InstrReady, WriteA, WriteB, WriteO}), 16'b1000);
        check("b2b_rb", 16'(rb), 16'h55);
        @(negedge Clock);
        exec_chk("b2b_mov", 3'b100, 8'h55);
        InstrValid = 1'b0;
        flag_chk("b2b_mov", 1'b1, 1'b0);
        check("b2b_ra", 16'(ra), 16'h55);

        saved = nstb;
        send(8'h10);
        check("rimm_busy", 16'(Busy), 16'd1);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("rimm_state", 16'({InstrReady, Busy}), 16'b10);
        check("rimm_flags", 16'({Carry, Zero}), 16'd0);
        repeat (2) @(negedge Clock);
        check("rimm_nostb", 16'(nstb), 16'(saved));
        send(8'h40);
        exec_chk("rimm_add", 3'b100, 8'hAA);
        flag_chk("rimm_add", 1'b0, 1'b0);
        check("rimm_ra", 16'(ra), 16'hAA);
        check("rimm_rb", 16'(rb), 16'h55);

        send(8'h10);
        InstrValid = 1'b0;
        repeat (3) @(negedge Clock);
        check("gap_wait", 16'({Busy, InstrReady, WriteA, WriteB, WriteO}), 16'b11000);
        send(8'hAA);
        exec_chk("gap_ldiB", 3'b010, 8'hAA);
        flag_chk("gap_ldiB", 1'b0, 1'b0);

        saved = nstb;
        send(8'h70);
        exec_chk("none_add", 3'b000, 8'h54);
        flag_chk("none_add", 1'b1, 1'b0);
        check("none_nostb", 16'(nstb), 16'(saved));
        check("none_regs", {ra, rb}, 16'hAAAA);

        send(8'hCE);
        exec_chk("mov_zero", 3'b100, 8'h00);
        flag_chk("mov_zero", 1'b1, 1'b1);
        check("mov_zero_ra", 16'(ra), 16'h00);

        ldi(8'h00, 8'hAA);
        flag_chk("ldiA3", 1'b1, 1'b0);
        send(8'hB0);
        exec_chk("none_sub", 3'b000, 8'h00);
        flag_chk("none_sub", 1'b0, 1'b1);
        check("none_sub_regs", {ra, rb}, 16'hAAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
